// File: rtl/dsp_slice_pkg.sv
// Shared definitions for the DSP MAC slice: OPMODE bit map and X/Z mux encodings.
package dsp_slice_pkg;

    localparam int unsigned OPMODE_W     = 8;
    localparam int unsigned OP_X_LSB     = 0;
    localparam int unsigned OP_Z_LSB     = 2;
    localparam int unsigned OP_PREADD_EN = 4;
    localparam int unsigned OP_CIN       = 5;
    localparam int unsigned OP_PRESUB    = 6;
    localparam int unsigned OP_POSTSUB   = 7;

    // Post-adder controls carried through the M stage: {OPMODE[7], OPMODE[5], OPMODE[3:0]}
    localparam int unsigned CTL_W        = 6;
    localparam int unsigned CTL_SUB      = 5;
    localparam int unsigned CTL_CIN      = 4;
    localparam int unsigned CTL_Z_LSB    = 2;
    localparam int unsigned CTL_X_LSB    = 0;

    typedef enum logic [1:0] {
        X_ZERO = 2'd0,
        X_M    = 2'd1,
        X_P    = 2'd2,
        X_AB   = 2'd3
    } xsel_e;

    typedef enum logic [1:0] {
        Z_ZERO = 2'd0,
        Z_PCIN = 2'd1,
        Z_P    = 2'd2,
        Z_C    = 2'd3
    } zsel_e;

endpackage

// File: rtl/dsp_pipe_reg.sv
// Generic pipeline stage: clock-enabled register with synchronous reset and optional bypass.
module dsp_pipe_reg #(
    parameter int unsigned WIDTH  = 1,
    parameter bit          BYPASS = 1'b0
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_ce,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Stage register: reset wins over enable, otherwise load on enable and hold on idle
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_q <= '0;
        end else if (i_ce) begin
            r_q <= i_d;
        end
    end

    assign o_q = BYPASS ? i_d : r_q;

endmodule

// File: rtl/dsp_mac_slice.sv
// DSP MAC slice: input stage, pre-adder, multiplier stage, X/Z post-adder with
// saturation and pattern detect, registered P output with cascade copy.
module dsp_mac_slice
    import dsp_slice_pkg::*;
#(
    parameter int unsigned          A_WIDTH    = 18,
    parameter int unsigned          B_WIDTH    = 18,
    parameter int unsigned          P_WIDTH    = 48,
    parameter int unsigned          IREG       = 1,
    parameter int unsigned          MREG       = 1,
    parameter string                CARRYINSEL = "OPMODE5",
    parameter int unsigned          SATURATE   = 0,
    parameter logic [P_WIDTH-1:0]   PATTERN    = '0,
    parameter logic [P_WIDTH-1:0]   MASK       = '0
) (
    input  logic                       clk,
    input  logic                       RST,
    input  logic [A_WIDTH-1:0]         A,
    input  logic [B_WIDTH-1:0]         B,
    input  logic [B_WIDTH-1:0]         D,
    input  logic [P_WIDTH-1:0]         C,
    input  logic [P_WIDTH-1:0]         PCIN,
    input  logic                       CARRYIN,
    input  logic [OPMODE_W-1:0]        OPMODE,
    input  logic                       CEI,
    input  logic                       CEM,
    input  logic                       CEP,
    output logic [B_WIDTH-1:0]         BCOUT,
    output logic [A_WIDTH+B_WIDTH-1:0] M,
    output logic [P_WIDTH-1:0]         P,
    output logic [P_WIDTH-1:0]         PCOUT,
    output logic                       CARRYOUT,
    output logic                       OVERFLOW,
    output logic                       PATTERNDETECT
);

    localparam int unsigned MW  = A_WIDTH + B_WIDTH;
    localparam int unsigned SW  = P_WIDTH + 1;
    localparam int unsigned PSW = P_WIDTH + 3;
    localparam bit          I_BYP   = (IREG == 0);
    localparam bit          M_BYP   = (MREG == 0);
    localparam bit          CIN_EXT = (CARRYINSEL == "CARRYIN");
    localparam bit          SAT_EN  = (SATURATE != 0);

    logic [A_WIDTH-1:0]  w_a1;
    logic [B_WIDTH-1:0]  w_b1;
    logic [B_WIDTH-1:0]  w_d1;
    logic [P_WIDTH-1:0]  w_c1;
    logic [P_WIDTH-1:0]  w_pcin1;
    logic                w_cin1;
    logic [OPMODE_W-1:0] w_op1;

    logic [B_WIDTH-1:0]  w_pre;
    logic [MW-1:0]       w_prod;
    logic [MW-1:0]       w_m;
    logic [CTL_W-1:0]    w_ctl1;
    logic [CTL_W-1:0]    w_ctl2;
    logic                w_cin2;
    logic [P_WIDTH-1:0]  w_c2;

    logic [P_WIDTH-1:0]  w_x;
    logic [P_WIDTH-1:0]  w_z;
    logic                w_cin;
    logic [SW-1:0]       w_xc;
    logic [SW-1:0]       w_s;
    logic [P_WIDTH-1:0]  w_pnext;
    logic                w_ovf;
    logic                w_pd;
    logic [PSW-1:0]      w_pstage_d;
    logic [PSW-1:0]      w_pstage_q;
    logic [P_WIDTH-1:0]  w_p;

    // Input stage
    dsp_pipe_reg #(.WIDTH(A_WIDTH),  .BYPASS(I_BYP)) u_in_a    (.clk(clk), .i_rst(RST), .i_ce(CEI), .i_d(A),       .o_q(w_a1));
    dsp_pipe_reg #(.WIDTH(B_WIDTH),  .BYPASS(I_BYP)) u_in_b    (.clk(clk), .i_rst(RST), .i_ce(CEI), .i_d(B),       .o_q(w_b1));
    dsp_pipe_reg #(.WIDTH(B_WIDTH),  .BYPASS(I_BYP)) u_in_d    (.clk(clk), .i_rst(RST), .i_ce(CEI), .i_d(D),       .o_q(w_d1));
    dsp_pipe_reg #(.WIDTH(P_WIDTH),  .BYPASS(I_BYP)) u_in_c    (.clk(clk), .i_rst(RST), .i_ce(CEI), .i_d(C),       .o_q(w_c1));
    dsp_pipe_reg #(.WIDTH(P_WIDTH),  .BYPASS(I_BYP)) u_in_pcin (.clk(clk), .i_rst(RST), .i_ce(CEI), .i_d(PCIN),    .o_q(w_pcin1));
    dsp_pipe_reg #(.WIDTH(1),        .BYPASS(I_BYP)) u_in_cin  (.clk(clk), .i_rst(RST), .i_ce(CEI), .i_d(CARRYIN), .o_q(w_cin1));
    dsp_pipe_reg #(.WIDTH(OPMODE_W), .BYPASS(I_BYP)) u_in_op   (.clk(clk), .i_rst(RST), .i_ce(CEI), .i_d(OPMODE),  .o_q(w_op1));

    // Pre-adder: D+B or D-B when enabled, otherwise B passes through
    always_comb begin
        w_pre = w_b1;
        if (w_op1[OP_PREADD_EN]) begin
            w_pre = w_op1[OP_PRESUB] ? (w_d1 - w_b1) : (w_d1 + w_b1);
        end
    end

    assign BCOUT  = w_pre;
    assign w_prod = MW'(w_a1) * MW'(w_pre);
    assign w_ctl1 = {w_op1[OP_POSTSUB], w_op1[OP_CIN], w_op1[3:0]};

    // Multiplier stage plus the post-adder controls that must stay aligned with M
    dsp_pipe_reg #(.WIDTH(MW),      .BYPASS(M_BYP)) u_m_prod (.clk(clk), .i_rst(RST), .i_ce(CEM), .i_d(w_prod), .o_q(w_m));
    dsp_pipe_reg #(.WIDTH(CTL_W),   .BYPASS(M_BYP)) u_m_ctl  (.clk(clk), .i_rst(RST), .i_ce(CEM), .i_d(w_ctl1), .o_q(w_ctl2));
    dsp_pipe_reg #(.WIDTH(1),       .BYPASS(M_BYP)) u_m_cin  (.clk(clk), .i_rst(RST), .i_ce(CEM), .i_d(w_cin1), .o_q(w_cin2));
    dsp_pipe_reg #(.WIDTH(P_WIDTH), .BYPASS(M_BYP)) u_m_c    (.clk(clk), .i_rst(RST), .i_ce(CEM), .i_d(w_c1),   .o_q(w_c2));

    assign M = w_m;

    // X and Z operand selection; P feedback is the registered P
    always_comb begin
        w_x = '0;
        case (xsel_e'(w_ctl2[CTL_X_LSB +: 2]))
            X_ZERO:  w_x = '0;
            X_M:     w_x = P_WIDTH'(w_m);
            X_P:     w_x = w_p;
            X_AB:    w_x = P_WIDTH'({w_a1, w_b1});
            default: w_x = '0;
        endcase
        w_z = '0;
        case (zsel_e'(w_ctl2[CTL_Z_LSB +: 2]))
            Z_ZERO:  w_z = '0;
            Z_PCIN:  w_z = w_pcin1;
            Z_P:     w_z = w_p;
            Z_C:     w_z = w_c2;
            default: w_z = '0;
        endcase
    end

    // Post-adder with optional clamp on carry/borrow and masked pattern compare on the loaded value
    always_comb begin
        w_cin   = CIN_EXT ? w_cin2 : w_ctl2[CTL_CIN];
        w_xc    = SW'(w_x) + SW'(w_cin);
        w_s     = w_ctl2[CTL_SUB] ? (SW'(w_z) - w_xc) : (SW'(w_z) + w_xc);
        w_pnext = w_s[P_WIDTH-1:0];
        w_ovf   = 1'b0;
        if (SAT_EN && w_s[P_WIDTH]) begin
            w_pnext = w_ctl2[CTL_SUB] ? {P_WIDTH{1'b0}} : {P_WIDTH{1'b1}};
            w_ovf   = 1'b1;
        end
        w_pd       = (((w_pnext ^ PATTERN) & ~MASK) == '0);
        w_pstage_d = {w_pnext, w_s[P_WIDTH], w_ovf, w_pd};
    end

    // Output stage, always registered
    dsp_pipe_reg #(.WIDTH(PSW), .BYPASS(1'b0)) u_p (.clk(clk), .i_rst(RST), .i_ce(CEP), .i_d(w_pstage_d), .o_q(w_pstage_q));

    assign w_p           = w_pstage_q[PSW-1:3];
    assign CARRYOUT      = w_pstage_q[2];
    assign OVERFLOW      = w_pstage_q[1];
    assign PATTERNDETECT = w_pstage_q[0];
    assign P             = w_p;
    assign PCOUT         = w_p;

endmodule

// File: tb/tb_dsp_mac_slice.sv
// Directed bench for dsp_mac_slice: default, saturating/external-carry and fully combinational variants.
module tb_dsp_mac_slice;

    logic        clk;
    logic        rst;
    logic [17:0] a;
    logic [24:0] a25;
    logic [17:0] b;
    logic [17:0] d;
    logic [47:0] c;
    logic [47:0] pcin;
    logic        carryin;
    logic [7:0]  opmode;
    logic        cei, cem, cep;

    logic [17:0] def_bcout, sat_bcout, cmb_bcout;
    logic [35:0] def_m, sat_m;
    logic [42:0] cmb_m;
    logic [47:0] def_p, def_pcout, sat_p, sat_pcout, cmb_p, cmb_pcout;
    logic        def_co, def_ovf, def_pd;
    logic        sat_co, sat_ovf, sat_pd;
    logic        cmb_co, cmb_ovf, cmb_pd;

    int n_cmp = 0;
    int n_mis = 0;

    localparam logic [47:0] ALL1 = {48{1'b1}};

    dsp_mac_slice u_def (
        .clk(clk), .RST(rst), .A(a), .B(b), .D(d), .C(c), .PCIN(pcin), .CARRYIN(carryin),
        .OPMODE(opmode), .CEI(cei), .CEM(cem), .CEP(cep),
        .BCOUT(def_bcout), .M(def_m), .P(def_p), .PCOUT(def_pcout),
        .CARRYOUT(def_co), .OVERFLOW(def_ovf), .PATTERNDETECT(def_pd)
    );

    dsp_mac_slice #(.SATURATE(1), .CARRYINSEL("CARRYIN")) u_sat (
        .clk(clk), .RST(rst), .A(a), .B(b), .D(d), .C(c), .PCIN(pcin), .CARRYIN(carryin),
        .OPMODE(opmode), .CEI(cei), .CEM(cem), .CEP(cep),
        .BCOUT(sat_bcout), .M(sat_m), .P(sat_p), .PCOUT(sat_pcout),
        .CARRYOUT(sat_co), .OVERFLOW(sat_ovf), .PATTERNDETECT(sat_pd)
    );

    dsp_mac_slice #(.A_WIDTH(25), .IREG(0), .MREG(0)) u_cmb (
        .clk(clk), .RST(rst), .A(a25), .B(b), .D(d), .C(c), .PCIN(pcin), .CARRYIN(carryin),
        .OPMODE(opmode), .CEI(cei), .CEM(cem), .CEP(cep),
        .BCOUT(cmb_bcout), .M(cmb_m), .P(cmb_p), .PCOUT(cmb_pcout),
        .CARRYOUT(cmb_co), .OVERFLOW(cmb_ovf), .PATTERNDETECT(cmb_pd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; cei = 1'b1; cem = 1'b1; cep = 1'b1;
        a = 18'($urandom); a25 = 25'($urandom); b = 18'($urandom); d = 18'($urandom);
        c = 48'({$urandom, $urandom}); pcin = 48'({$urandom, $urandom});
        carryin = 1'b1; opmode = 8'($urandom);

        // Reset with random inputs
        step(1);
        check("rst_bcout", 64'(def_bcout), 64'd0);
        check("rst_m",     64'(def_m),     64'd0);
        check("rst_p",     64'(def_p),     64'd0);
        check("rst_pcout", 64'(def_pcout), 64'd0);
        check("rst_co",    64'(def_co),    64'd0);
        check("rst_ovf",   64'(def_ovf),   64'd0);
        check("rst_pd",    64'(def_pd),    64'd0);
        check("rst_sat_p", 64'(sat_p),     64'd0);

        // C + (D+B)*A, latency 3
        rst = 1'b0; a = 18'd1; b = 18'd2; c = 48'd3; d = 18'd4; pcin = 48'd0;
        carryin = 1'b1; opmode = 8'h1D;
        step(1);
        check("pre_add_bcout", 64'(def_bcout), 64'd6);
        step(1);
        check("m_stage", 64'(def_m), 64'd6);
        check("lat_p_edge2", 64'(def_p), 64'd0);
        step(1);
        check("mac_p", 64'(def_p), 64'd9);
        check("mac_pcout", 64'(def_pcout), 64'd9);
        check("mac_co", 64'(def_co), 64'd0);
        check("ext_cin_p", 64'(sat_p), 64'd10);

        opmode = 8'h3D; carryin = 1'b0;
        step(2);
        check("op5_p_edge2", 64'(def_p), 64'd9);
        step(1);
        check("op5_cin_p", 64'(def_p), 64'd10);
        check("ext_cin0_p", 64'(sat_p), 64'd9);

        // Pre-subtract D-B
        opmode = 8'h5D;
        step(1);
        check("pre_sub_bcout", 64'(def_bcout), 64'd2);
        step(2);
        check("pre_sub_p", 64'(def_p), 64'd5);

        // Accumulate P += (D+B)*A
        rst = 1'b1; step(1);
        rst = 1'b0; opmode = 8'h19;
        step(3);
        check("acc_p1", 64'(def_p), 64'd6);
        step(1);
        check("acc_p2", 64'(def_p), 64'd12);
        step(1);
        check("acc_p3", 64'(def_p), 64'd18);
        cep = 1'b0;
        step(1);
        check("acc_hold1", 64'(def_p), 64'd18);
        step(3);
        check("acc_hold4", 64'(def_p), 64'd18);
        cep = 1'b1;
        step(1);
        check("acc_resume", 64'(def_p), 64'd24);

        // Reset mid-accumulation with all enables low
        rst = 1'b1; cei = 1'b0; cem = 1'b0; cep = 1'b0;
        step(1);
        check("midrst_p", 64'(def_p), 64'd0);
        check("midrst_m", 64'(def_m), 64'd0);
        check("midrst_bcout", 64'(def_bcout), 64'd0);
        rst = 1'b0; cei = 1'b1; cem = 1'b1; cep = 1'b1;
        step(2);
        check("midrst_flush", 64'(def_p), 64'd0);
        step(1);
        check("midrst_restart", 64'(def_p), 64'd6);

        // P - P gives zero and a pattern hit
        opmode = 8'h8A;
        step(2);
        check("pmp_pre_p", 64'(def_p), 64'd18);
        check("pmp_pre_pd", 64'(def_pd), 64'd0);
        step(1);
        check("pmp_p", 64'(def_p), 64'd0);
        check("pmp_pd", 64'(def_pd), 64'd1);

        // Overflow on add: clamp vs wrap
        rst = 1'b1; step(1);
        rst = 1'b0; c = ALL1; opmode = 8'h1D; carryin = 1'b0;
        step(3);
        check("sat_add_p",   64'(sat_p),   64'(ALL1));
        check("sat_add_ovf", 64'(sat_ovf), 64'd1);
        check("sat_add_co",  64'(sat_co),  64'd1);
        check("wrap_add_p",  64'(def_p),   64'd5);
        check("wrap_add_co", 64'(def_co),  64'd1);
        check("wrap_add_ovf", 64'(def_ovf), 64'd0);

        // Underflow on subtract: clamp vs wrap
        c = 48'd3; opmode = 8'h9D;
        step(3);
        check("sat_sub_p",   64'(sat_p),   64'd0);
        check("sat_sub_ovf", 64'(sat_ovf), 64'd1);
        check("wrap_sub_p",  64'(def_p),   64'(ALL1 - 48'd2));

        // Fully combinational front end with 25-bit A
        a25 = 25'h100_0000; b = 18'd3; c = 48'd0; opmode = 8'h0D;
        step(1);
        check("cmb_p", 64'(cmb_p), 64'h300_0000);
        check("cmb_pcout", 64'(cmb_pcout), 64'h300_0000);

        // Input stage holds with CEI low
        check("cei_bcout", 64'(def_bcout), 64'd3);
        cei = 1'b0; b = 18'd7;
        step(1);
        check("cei_hold_bcout", 64'(def_bcout), 64'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
